// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detector pipeline stages.
package edge_pkg;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 14;

  typedef logic [7:0]           pixel_t;
  typedef pixel_t [IN_W-1:0]    row16_t;
  typedef pixel_t [OUT_W-1:0]   row14_t;

  typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel: window in, saturated |Gx|+|Gy| out.
module sobel_kernel import edge_pkg::*; (
  input  logic [71:0] win,  // pixel (r,c) at bits [8*(3r+c) +: 8]
  output logic [7:0]  mag
);

  pixel_t            p [3][3];
  logic       [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx, gy;
  logic       [9:0]  ax, ay;
  logic       [11:0] mag_raw;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p[r][c] = win[(3*r+c)*8 +: 8];
      end
    end
  end

  // Each weighted sum peaks at 1020, so it stays non-negative as 11-bit signed.
  assign gx_pos = {3'b0, p[0][2]} + {2'b0, p[1][2], 1'b0} + {3'b0, p[2][2]};
  assign gx_neg = {3'b0, p[0][0]} + {2'b0, p[1][0], 1'b0} + {3'b0, p[2][0]};
  assign gy_pos = {3'b0, p[0][0]} + {2'b0, p[0][1], 1'b0} + {3'b0, p[0][2]};
  assign gy_neg = {3'b0, p[2][0]} + {2'b0, p[2][1], 1'b0} + {3'b0, p[2][2]};

  assign gx = $signed(gx_pos) - $signed(gx_neg);
  assign gy = $signed(gy_pos) - $signed(gy_neg);

  assign ax = gx[10] ? 10'(-gx) : gx[9:0];
  assign ay = gy[10] ? 10'(-gy) : gy[9:0];

  assign mag_raw = {2'b0, ax} + {2'b0, ay};
  assign mag     = (mag_raw > 12'd255) ? 8'hff : mag_raw[7:0];

endmodule

// File: rtl/gradient_controller.sv
// Row-streaming Sobel gradient stage: 3-row window, one kernel shared across 14 columns.
module gradient_controller import edge_pkg::*; (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         anchor_moving,
  input  logic [31:0]  anchor_x,
  input  logic [31:0]  anchor_y,
  input  logic [127:0] gradient_in,
  output logic [111:0] gradient_out,
  output logic         gradient_final
);

  localparam logic [3:0] LastCol = 4'(OUT_W - 1);

  state_t     state_q, state_d;
  logic [3:0] k_q, k_d;
  logic       capture, store, commit;

  row16_t row_in;
  row16_t top_q, mid_q, bot_q;
  row14_t res_q, out_q;
  logic   final_q;

  logic [3:0]  c1, c2;
  logic [71:0] win;
  logic [7:0]  mag;

  // Strip position is informational only.
  logic unused_anchor;
  assign unused_anchor = ^anchor_y;

  assign row_in = gradient_in;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    capture = 1'b0;
    store   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (anchor_moving) begin
          capture = 1'b1;
          k_d     = '0;
          state_d = COMP;
        end
      end
      COMP: begin
        store = 1'b1;
        if (k_q == LastCol) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      DONE: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // First row of a strip has no neighbours above, so replicate it into all three.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
    end else if (capture) begin
      if (anchor_x == 32'd0) begin
        top_q <= row_in;
        mid_q <= row_in;
        bot_q <= row_in;
      end else begin
        top_q <= mid_q;
        mid_q <= bot_q;
        bot_q <= row_in;
      end
    end
  end

  assign c1  = k_q + 4'd1;
  assign c2  = k_q + 4'd2;
  assign win = {bot_q[c2], bot_q[c1], bot_q[k_q],
                mid_q[c2], mid_q[c1], mid_q[k_q],
                top_q[c2], top_q[c1], top_q[k_q]};

  sobel_kernel u_kernel (
    .win (win),
    .mag (mag)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      res_q <= '0;
    end else if (store) begin
      res_q[k_q] <= mag;
    end
  end

  // Results are staged so the consumer never sees a partially updated row.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_q   <= '0;
      final_q <= 1'b0;
    end else begin
      final_q <= commit;
      if (commit) begin
        out_q <= res_q;
      end
    end
  end

  assign gradient_out   = out_q;
  assign gradient_final = final_q;

endmodule

// File: tb/tb_gradient_controller.sv
// Randomised bench for gradient_controller against a golden 3x3 Sobel model.
module tb_gradient_controller;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         anchor_moving;
  logic [31:0]  anchor_x;
  logic [31:0]  anchor_y;
  logic [127:0] gradient_in;
  logic [111:0] gradient_out;
  logic         gradient_final;

  int n_chk = 0;
  int n_err = 0;
  int m_rows [3][16];

  always #5 clk = ~clk;

  gradient_controller dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .anchor_moving  (anchor_moving),
    .anchor_x       (anchor_x),
    .anchor_y       (anchor_y),
    .gradient_in    (gradient_in),
    .gradient_out   (gradient_out),
    .gradient_final (gradient_final)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int golden(input int k);
    int wa [3] = '{1, 2, 1};
    int wd [3] = '{-1, 0, 1};
    int gx = 0;
    int gy = 0;
    int m;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        gx += wa[r] * wd[c] * m_rows[r][k+c];
        gy += -wd[r] * wa[c] * m_rows[r][k+c];
      end
    end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic model_push(input logic [31:0] ax, input logic [127:0] row);
    for (int i = 0; i < 16; i++) begin
      if (ax == 32'd0) begin
        m_rows[0][i] = int'(row[8*i +: 8]);
        m_rows[1][i] = int'(row[8*i +: 8]);
        m_rows[2][i] = int'(row[8*i +: 8]);
      end else begin
        m_rows[0][i] = m_rows[1][i];
        m_rows[1][i] = m_rows[2][i];
        m_rows[2][i] = int'(row[8*i +: 8]);
      end
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 16; i++) m_rows[r][i] = 0;
  endtask

  function automatic logic [127:0] fill_row(input int v);
    logic [127:0] row;
    for (int i = 0; i < 16; i++) row[8*i +: 8] = 8'(v);
    return row;
  endfunction

  function automatic logic [127:0] rand_row();
    logic [127:0] row;
    int base;
    int v;
    base = int'($urandom_range(0, 255));
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 255));
      else v = base + int'($urandom_range(0, 30)) - 15;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      row[8*i +: 8] = 8'(v);
    end
    return row;
  endfunction

  // Strobe one row, optionally keep the strobe asserted for `hold` cycles of COMP
  // with junk data, then check pulse timing and all 14 outputs.
  task automatic run_frame(input string name, input logic [31:0] ax,
                           input logic [127:0] row, input int hold);
    int cnt;
    @(negedge clk);
    anchor_moving = 1'b1;
    anchor_x      = ax;
    anchor_y      = $urandom;
    gradient_in   = row;
    model_push(ax, row);
    @(negedge clk);
    anchor_moving = (hold > 0);
    cnt = 0;
    while (cnt < 40) begin
      if (anchor_moving) begin
        gradient_in = {$urandom, $urandom, $urandom, $urandom};
        anchor_x    = $urandom_range(0, 3);
      end
      @(negedge clk);
      cnt++;
      anchor_moving = (cnt < hold);
      if (gradient_final) break;
    end
    anchor_moving = 1'b0;
    check({name, "_latency"}, cnt, 15);
    for (int k = 0; k < 14; k++)
      check($sformatf("%s_px%0d", name, k), int'(gradient_out[8*k +: 8]), golden(k));
    @(negedge clk);
    check({name, "_pulse_width"}, int'(gradient_final), 0);
  endtask

  initial begin
    logic [127:0] row;
    int pulses;
    int nz;

    n_rst         = 1'b0;
    anchor_moving = 1'b0;
    anchor_x      = '0;
    anchor_y      = '0;
    gradient_in   = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_out", int'(|gradient_out), 0);
    check("reset_final", int'(gradient_final), 0);
    n_rst = 1'b1;

    run_frame("zero", 32'd0, fill_row(0), 0);
    run_frame("flat100", 32'd0, fill_row(100), 0);

    row = fill_row(0);
    for (int i = 8; i < 16; i++) row[8*i +: 8] = 8'd200;
    run_frame("step", 32'd0, row, 0);
    check("step_px6_sat", int'(gradient_out[8*6 +: 8]), 255);

    run_frame("vert_a", 32'd0, fill_row(0), 0);
    run_frame("vert_b", 32'd1, fill_row(200), 0);
    check("vert_px0_sat", int'(gradient_out[7:0]), 255);

    row = fill_row(0);
    row[8*8 +: 8] = 8'd10;
    run_frame("spike", 32'd0, row, 0);
    check("spike_px6", int'(gradient_out[8*6 +: 8]), 40);
    check("spike_px8", int'(gradient_out[8*8 +: 8]), 40);

    // Strobe held through COMP must not shift the window again.
    run_frame("hold_a", 32'd1, rand_row(), 10);
    run_frame("hold_b", 32'd1, rand_row(), 0);

    // Reset in the middle of COMP aborts the frame.
    @(negedge clk);
    anchor_moving = 1'b1;
    anchor_x      = 32'd0;
    gradient_in   = fill_row(250);
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    #1;
    nz = 0;
    for (int k = 0; k < 14; k++) if (gradient_out[8*k +: 8] != 8'd0) nz++;
    check("abort_out_nonzero", nz, 0);
    check("abort_final", int'(gradient_final), 0);
    anchor_moving = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (gradient_final) pulses++;
    end
    check("abort_pulses", pulses, 0);
    model_clear();
    run_frame("post_abort", 32'd1, rand_row(), 0);

    for (int f = 0; f < 25; f++) begin
      run_frame($sformatf("rnd%0d", f),
                ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)),
                rand_row(), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
